mem_resp_stage: RTL and testbench



---
 rtl/mem_resp_stage_pkg.sv | 25 ++
 rtl/mem_resp_stage_load_align.sv | 77 +++++++
 rtl/mem_resp_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_resp_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_stage_pkg.sv
// ============================================================================
// mem_resp_stage_pkg: load-op one-hot bit indices and MEM-stage defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_resp_stage_pkg;

  // One-hot load op layout, MSB first: {lw, lb, lbu, lh, lhu, lwl, lwr}
  localparam int c_op_w   = 7;
  localparam int c_op_lw  = 6;
  localparam int c_op_lb  = 5;
  localparam int c_op_lbu = 4;
  localparam int c_op_lh  = 3;
  localparam int c_op_lhu = 2;
  localparam int c_op_lwl = 1;
  localparam int c_op_lwr = 0;

  localparam int c_max_out_default = 2;

  typedef logic [c_op_w-1:0] load_op_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_stage_load_align.sv
// ============================================================================
// load_align: combinational byte/half/word extraction and lwl/lwr merge
// Rev 1.0
// ============================================================================
`default_nettype none

module load_align
  import mem_resp_stage_pkg::*;
#(
  parameter bit LWLR_EN = 1'b1
) (
  input  logic [c_op_w-1:0] op,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       rdata,
  input  logic [31:0]       rt_value,
  output logic [31:0]       result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  generate
    if (LWLR_EN) begin : g_lwlr
      // Little-endian: lwl fills from the MSB down, lwr from the LSB up
      always_comb begin
        case (addr_lo)
          2'd0: begin
            w_lwl = {rdata[7:0], rt_value[23:0]};
            w_lwr = rdata;
          end
          2'd1: begin
            w_lwl = {rdata[15:0], rt_value[15:0]};
            w_lwr = {rt_value[31:24], rdata[31:8]};
          end
          2'd2: begin
            w_lwl = {rdata[23:0], rt_value[7:0]};
            w_lwr = {rt_value[31:16], rdata[31:16]};
          end
          default: begin
            w_lwl = rdata;
            w_lwr = {rt_value[31:8], rdata[31:24]};
          end
        endcase
      end
    end else begin : g_no_lwlr
      assign w_lwl = '0;
      assign w_lwr = '0;
    end
  endgenerate

  always_comb begin
    result = '0;
    if (op[c_op_lw])       result = rdata;
    else if (op[c_op_lb])  result = {{24{w_byte[7]}}, w_byte};
    else if (op[c_op_lbu]) result = {24'd0, w_byte};
    else if (op[c_op_lh])  result = {{16{w_half[15]}}, w_half};
    else if (op[c_op_lhu]) result = {16'd0, w_half};
    else if (op[c_op_lwl]) result = w_lwl;
    else if (op[c_op_lwr]) result = w_lwr;
  end

endmodule

`default_nettype wire

// File: rtl/mem_resp_stage.sv
// ============================================================================
// mem_resp_stage: MEM pipeline stage collecting load responses, with flush discard
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int MAX_OUT = c_max_out_default,
  parameter bit LWLR_EN = 1'b1,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [c_op_w-1:0] es_load_op,
  input  logic [1:0]        es_addr_lo,
  input  logic [31:0]       es_rt_value,
  input  logic [31:0]       es_alu_result,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic [31:0]       es_pc,
  input  logic              es_ex,
  input  logic              es_req_sent,
  input  logic              es_flush_owed,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic [31:0]       ms_result,
  output logic              ms_ex,
  output logic              ms_fwd_valid,
  output logic              ms_fwd_stall
);

  logic              r_valid;
  logic              r_wait_data;
  logic              r_buf_valid;
  logic [31:0]       r_buf_data;
  logic [c_op_w-1:0] r_load_op;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_rt_value;
  logic [31:0]       r_alu_result;
  logic              r_gr_we;
  logic [4:0]        r_dest;
  logic [31:0]       r_pc;
  logic              r_ex;
  logic [CNT_W-1:0]  r_discard_cnt;

  logic              w_data_fresh;
  logic              w_ready_go;
  logic              w_transfer;
  logic              w_latch;
  logic              w_ms_owes;
  logic              w_dec;
  logic [1:0]        w_inc;
  logic [CNT_W+1:0]  w_cnt_sum;
  logic [31:0]       w_rdata;
  logic [31:0]       w_aligned;

  // A response only belongs to this stage once every discarded one has drained
  assign w_data_fresh   = data_ok && (r_discard_cnt == '0);
  assign w_ready_go     = !r_wait_data || r_buf_valid || w_data_fresh;
  assign ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_valid && w_ready_go;
  assign w_transfer     = ms_to_ws_valid && ws_allowin;
  assign w_latch        = es_to_ms_valid && ms_allowin && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_wait_data  <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= '0;
      r_load_op    <= '0;
      r_addr_lo    <= '0;
      r_rt_value   <= '0;
      r_alu_result <= '0;
      r_gr_we      <= 1'b0;
      r_dest       <= '0;
      r_pc         <= '0;
      r_ex         <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_wait_data <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (w_latch) begin
      r_valid      <= 1'b1;
      r_wait_data  <= (|es_load_op) && es_req_sent && !es_ex;
      r_buf_valid  <= 1'b0;
      r_load_op    <= es_load_op;
      r_addr_lo    <= es_addr_lo;
      r_rt_value   <= es_rt_value;
      r_alu_result <= es_alu_result;
      r_gr_we      <= es_gr_we;
      r_dest       <= es_dest;
      r_pc         <= es_pc;
      r_ex         <= es_ex;
    end else if (w_transfer) begin
      r_valid     <= 1'b0;
      r_wait_data <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (r_valid && r_wait_data && !r_buf_valid && w_data_fresh) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= rdata;
    end
  end

  // A response draining an older discarded request does not settle this one
  assign w_ms_owes = r_valid && r_wait_data && !r_buf_valid && !w_data_fresh;
  assign w_inc     = flush ? ({1'b0, w_ms_owes} + {1'b0, es_flush_owed}) : 2'd0;
  assign w_dec     = data_ok && (r_discard_cnt != '0);
  assign w_cnt_sum = {2'b00, r_discard_cnt} + {{CNT_W{1'b0}}, w_inc}
                   - {{(CNT_W + 1){1'b0}}, w_dec};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard_cnt <= '0;
    end else if (w_cnt_sum > (CNT_W + 2)'(MAX_OUT)) begin
      r_discard_cnt <= CNT_W'(MAX_OUT);
    end else begin
      r_discard_cnt <= w_cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (w_cnt_sum <= (CNT_W + 2)'(MAX_OUT))
        else $error("mem_resp_stage: discard counter exceeds MAX_OUT");
    end
  end

  assign w_rdata = r_buf_valid ? r_buf_data : rdata;

  load_align #(
    .LWLR_EN (LWLR_EN)
  ) u_load_align (
    .op       (r_load_op),
    .addr_lo  (r_addr_lo),
    .rdata    (w_rdata),
    .rt_value (r_rt_value),
    .result   (w_aligned)
  );

  assign ms_result    = (|r_load_op) ? w_aligned : r_alu_result;
  assign ms_pc        = r_pc;
  assign ms_dest      = r_dest;
  assign ms_ex        = r_valid && r_ex;
  assign ms_gr_we     = r_valid && r_gr_we && !r_ex;
  assign ms_fwd_valid = r_valid && r_gr_we;
  assign ms_fwd_stall = r_valid && r_wait_data && !r_buf_valid && !w_data_fresh;

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_stage.sv
// ============================================================================
// tb_mem_resp_stage: directed vectors and corner sequences for mem_resp_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_resp_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [6:0]  es_load_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_rt_value;
  logic [31:0] es_alu_result;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_pc;
  logic        es_ex;
  logic        es_req_sent;
  logic        es_flush_owed;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_ex;
  logic        ms_fwd_valid;
  logic        ms_fwd_stall;

  localparam logic [6:0] OP_LW  = 7'b1000000;
  localparam logic [6:0] OP_LB  = 7'b0100000;
  localparam logic [6:0] OP_LBU = 7'b0010000;
  localparam logic [6:0] OP_LH  = 7'b0001000;
  localparam logic [6:0] OP_LHU = 7'b0000100;
  localparam logic [6:0] OP_LWL = 7'b0000010;
  localparam logic [6:0] OP_LWR = 7'b0000001;

  typedef struct {
    logic [6:0]  op;
    logic [1:0]  lo;
    logic [31:0] rt;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];
  int   n_pass  = 0;
  int   n_total = 0;

  mem_resp_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allowin     (ms_allowin),
    .es_load_op     (es_load_op),
    .es_addr_lo     (es_addr_lo),
    .es_rt_value    (es_rt_value),
    .es_alu_result  (es_alu_result),
    .es_gr_we       (es_gr_we),
    .es_dest        (es_dest),
    .es_pc          (es_pc),
    .es_ex          (es_ex),
    .es_req_sent    (es_req_sent),
    .es_flush_owed  (es_flush_owed),
    .data_ok        (data_ok),
    .rdata          (rdata),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_pc          (ms_pc),
    .ms_gr_we       (ms_gr_we),
    .ms_dest        (ms_dest),
    .ms_result      (ms_result),
    .ms_ex          (ms_ex),
    .ms_fwd_valid   (ms_fwd_valid),
    .ms_fwd_stall   (ms_fwd_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] pc, input logic ex);
    es_load_op     = op;
    es_pc          = pc;
    es_ex          = ex;
    es_gr_we       = 1'b1;
    es_req_sent    = (op != 7'd0);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    es_req_sent    = 1'b0;
    es_ex          = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{OP_LB,  2'd3, 32'h0, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[1]  = '{OP_LBU, 2'd3, 32'h0, 32'h0, 32'h80FF_0000, 32'h0000_0080};
    vecs[2]  = '{OP_LB,  2'd1, 32'h0, 32'h0, 32'h0000_7F00, 32'h0000_007F};
    vecs[3]  = '{OP_LH,  2'd2, 32'h0, 32'h0, 32'h8001_1234, 32'hFFFF_8001};
    vecs[4]  = '{OP_LHU, 2'd0, 32'h0, 32'h0, 32'h8001_F234, 32'h0000_F234};
    vecs[5]  = '{OP_LW,  2'd0, 32'h0, 32'h0, 32'h1234_5678, 32'h1234_5678};
    vecs[6]  = '{OP_LWL, 2'd0, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h44BB_CCDD};
    vecs[7]  = '{OP_LWL, 2'd2, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h2233_44DD};
    vecs[8]  = '{OP_LWR, 2'd2, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'hAABB_1122};
    vecs[9]  = '{OP_LWR, 2'd1, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'hAA11_2233};
    vecs[10] = '{7'd0,   2'd0, 32'h0, 32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF};
    vecs[11] = '{OP_LWL, 2'd3, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h1122_3344};

    reset = 1'b1; flush = 1'b0; es_to_ms_valid = 1'b0; es_load_op = '0;
    es_addr_lo = '0; es_rt_value = '0; es_alu_result = '0; es_gr_we = 1'b0;
    es_dest = '0; es_pc = '0; es_ex = 1'b0; es_req_sent = 1'b0;
    es_flush_owed = 1'b0; data_ok = 1'b0; rdata = '0; ws_allowin = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #2;
    check("rst_allowin", 32'(ms_allowin), 32'd1);
    check("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_result", ms_result, 32'd0);
    check("rst_pc", ms_pc, 32'd0);
    check("rst_gr_we", 32'(ms_gr_we), 32'd0);
    check("rst_stall", 32'(ms_fwd_stall), 32'd0);

    // Single-instruction vectors, data returned the cycle after latch
    for (int i = 0; i < 12; i++) begin
      es_addr_lo    = vecs[i].lo;
      es_rt_value   = vecs[i].rt;
      es_alu_result = vecs[i].alu;
      es_dest       = 5'(i);
      issue(vecs[i].op, 32'h1000 + 32'(4 * i), 1'b0);
      if (vecs[i].op != 7'd0) begin
        #2;
        check($sformatf("vec%0d_stall", i), 32'(ms_fwd_stall), 32'd1);
        data_ok = 1'b1;
        rdata   = vecs[i].rd;
      end
      #2;
      check($sformatf("vec%0d_valid", i), 32'(ms_to_ws_valid), 32'd1);
      check($sformatf("vec%0d_result", i), ms_result, vecs[i].exp);
      check($sformatf("vec%0d_pc", i), ms_pc, 32'h1000 + 32'(4 * i));
      tick();
      data_ok = 1'b0;
    end

    // Response held in the buffer while WB stalls
    es_addr_lo = 2'd0;
    issue(OP_LW, 32'h2000, 1'b0);
    data_ok = 1'b1; rdata = 32'h1234_5678; ws_allowin = 1'b0;
    #2;
    check("buf_ready_same_cycle", 32'(ms_to_ws_valid), 32'd1);
    tick();
    data_ok = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      #2;
      check($sformatf("buf_hold%0d_valid", k), 32'(ms_to_ws_valid), 32'd1);
      check($sformatf("buf_hold%0d_result", k), ms_result, 32'h1234_5678);
      check($sformatf("buf_hold%0d_allowin", k), 32'(ms_allowin), 32'd0);
      check($sformatf("buf_hold%0d_stall", k), 32'(ms_fwd_stall), 32'd0);
      tick();
    end
    ws_allowin = 1'b1;
    #2;
    check("buf_release_result", ms_result, 32'h1234_5678);
    tick();
    #2;
    check("buf_drained", 32'(ms_to_ws_valid), 32'd0);
    issue(OP_LW, 32'h2004, 1'b0);
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    #2;
    check("buf_next_valid", 32'(ms_to_ws_valid), 32'd1);
    check("buf_next_result", ms_result, 32'hCAFE_F00D);
    tick();
    data_ok = 1'b0;

    // Flush with two responses owed; the third response is the new load's
    issue(OP_LW, 32'h3000, 1'b0);
    flush = 1'b1; es_flush_owed = 1'b1;
    es_load_op = OP_LW; es_pc = 32'h3004; es_req_sent = 1'b1; es_to_ms_valid = 1'b1;
    tick();
    flush = 1'b0; es_flush_owed = 1'b0; es_to_ms_valid = 1'b0; es_req_sent = 1'b0;
    #2;
    check("flush_cleared", 32'(ms_to_ws_valid), 32'd0);
    check("flush_ignored_es", 32'(ms_fwd_stall), 32'd0);
    issue(OP_LW, 32'h3008, 1'b0);
    for (int k = 0; k < 2; k++) begin
      data_ok = 1'b1; rdata = 32'h1111_1111 * 32'(k + 1);
      #2;
      check($sformatf("discard%0d_valid", k), 32'(ms_to_ws_valid), 32'd0);
      check($sformatf("discard%0d_stall", k), 32'(ms_fwd_stall), 32'd1);
      tick();
    end
    rdata = 32'h3333_3333;
    #2;
    check("post_discard_valid", 32'(ms_to_ws_valid), 32'd1);
    check("post_discard_result", ms_result, 32'h3333_3333);
    check("post_discard_pc", ms_pc, 32'h3008);
    tick();
    data_ok = 1'b0;
    #2;
    check("post_discard_drained", 32'(ms_to_ws_valid), 32'd0);

    // Excepting load never waits for data
    issue(OP_LB, 32'h4000, 1'b1);
    #2;
    check("ex_valid", 32'(ms_to_ws_valid), 32'd1);
    check("ex_flag", 32'(ms_ex), 32'd1);
    check("ex_gr_we", 32'(ms_gr_we), 32'd0);
    check("ex_stall", 32'(ms_fwd_stall), 32'd0);
    tick();
    #2;
    check("ex_drained", 32'(ms_to_ws_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
